// File: rtl/ota_bitstream_decimator.sv
// ota_bitstream_decimator: counts ones of the comparator bitstream over a
// programmable window (64..512 cycles), scales the count to an 8-bit sample
// and offers it on a valid/ready port with a sticky overrun flag.
module ota_bitstream_decimator (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       bit_in,
  input  logic [1:0] osr_sel,
  input  logic       clear_ovr,
  output logic [7:0] sample,
  output logic       sample_valid,
  input  logic       sample_ready,
  output logic       overrun,
  output logic       busy
);

  localparam int unsigned CNT_W = 9;   // window counter, up to 511
  localparam int unsigned TOT_W = 10;  // ones total, up to 512
  localparam int unsigned SCL_W = 11;  // scaled value before saturation
  localparam int unsigned SMP_W = 8;   // output sample width

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_ACCUM = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic               r_sync1;
  logic               r_sync2;
  logic               r_prime_cnt;
  logic [CNT_W-1:0]   r_cnt;
  logic [TOT_W-1:0]   r_ones;
  logic [1:0]         r_osr;
  logic [SMP_W-1:0]   r_sample;
  logic               r_valid;
  logic               r_overrun;
  logic               r_busy;

  logic               w_win_end;
  logic [CNT_W-1:0]   w_last;
  logic [TOT_W-1:0]   w_total;
  logic [SCL_W-1:0]   w_scaled;
  logic [SMP_W-1:0]   w_sample_next;
  logic               w_xfer;
  logic               w_load;
  logic               w_drop;

  // Two-flop synchronizer for the asynchronous comparator bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= bit_in;
      r_sync2 <= r_sync1;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Last counter value of the active window (N-1)
  always_comb begin
    w_last = CNT_W'(63);
    case (r_osr)
      2'd0:    w_last = CNT_W'(63);
      2'd1:    w_last = CNT_W'(127);
      2'd2:    w_last = CNT_W'(255);
      default: w_last = CNT_W'(511);
    endcase
  end

  // Next-state logic; enable low aborts from any state
  always_comb begin
    w_next_state = r_state;
    w_win_end    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (enable) w_next_state = ST_PRIME;
      end
      ST_PRIME: begin
        if (r_prime_cnt) w_next_state = ST_ACCUM;
      end
      ST_ACCUM: begin
        if (r_cnt == w_last) w_win_end = 1'b1;
      end
      default: w_next_state = ST_IDLE;
    endcase
    if (!enable) begin
      w_next_state = ST_IDLE;
      w_win_end    = 1'b0;
    end
  end

  // Two-cycle prime counter that lets the synchronizer flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prime_cnt <= 1'b0;
    end else if (r_state == ST_PRIME && enable) begin
      r_prime_cnt <= ~r_prime_cnt;
    end else begin
      r_prime_cnt <= 1'b0;
    end
  end

  // Window length is captured on PRIME entry and at each window boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_osr <= 2'd0;
    end else if ((r_state == ST_IDLE && w_next_state == ST_PRIME) || w_win_end) begin
      r_osr <= osr_sel;
    end
  end

  // Ones accumulator and window counter; cleared outside ACCUM and at window end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_ones <= '0;
    end else if (r_state == ST_ACCUM && enable && !w_win_end) begin
      r_cnt  <= r_cnt + CNT_W'(1);
      r_ones <= r_ones + TOT_W'(r_sync2);
    end else begin
      r_cnt  <= '0;
      r_ones <= '0;
    end
  end

  // Window total scaled to 256 full-scale and saturated to 8 bits
  always_comb begin
    w_total  = r_ones + TOT_W'(r_sync2);
    w_scaled = SCL_W'(w_total);
    case (r_osr)
      2'd0:    w_scaled = SCL_W'(w_total) << 2;
      2'd1:    w_scaled = SCL_W'(w_total) << 1;
      2'd2:    w_scaled = SCL_W'(w_total);
      default: w_scaled = SCL_W'(w_total) >> 1;
    endcase
    if (w_scaled > SCL_W'(255)) begin
      w_sample_next = SMP_W'(255);
    end else begin
      w_sample_next = w_scaled[SMP_W-1:0];
    end
  end

  // Handshake decode: load on free slot or same-edge transfer, else drop
  always_comb begin
    w_xfer = r_valid && sample_ready;
    w_load = w_win_end && (!r_valid || w_xfer);
    w_drop = w_win_end && r_valid && !w_xfer;
  end

  // Output sample register and valid flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sample <= '0;
      r_valid  <= 1'b0;
    end else if (w_load) begin
      r_sample <= w_sample_next;
      r_valid  <= 1'b1;
    end else if (w_xfer) begin
      r_valid  <= 1'b0;
    end
  end

  // Sticky overrun; a drop on the same edge as a clear keeps it set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overrun <= 1'b0;
    end else if (w_drop) begin
      r_overrun <= 1'b1;
    end else if (clear_ovr) begin
      r_overrun <= 1'b0;
    end
  end

  // Registered busy, high while PRIME or ACCUM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= 1'b0;
    end else begin
      r_busy <= (w_next_state != ST_IDLE);
    end
  end

  assign sample       = r_sample;
  assign sample_valid = r_valid;
  assign overrun      = r_overrun;
  assign busy         = r_busy;

endmodule

// File: tb/tb_ota_bitstream_decimator.sv
// Bench for ota_bitstream_decimator: table of window/pattern records plus
// hand-written back-pressure, abort, mid-window osr change and reset cases.
module tb_ota_bitstream_decimator;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       bit_in;
  logic [1:0] osr_sel;
  logic       clear_ovr;
  logic [7:0] sample;
  logic       sample_valid;
  logic       sample_ready;
  logic       overrun;
  logic       busy;

  ota_bitstream_decimator dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .bit_in       (bit_in),
    .osr_sel      (osr_sel),
    .clear_ovr    (clear_ovr),
    .sample       (sample),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .overrun      (overrun),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // mode: 0 const 0, 1 const 1, 2 toggle, 3 one-in-four, 4 three-in-four
  typedef struct {
    logic [1:0] osr;
    int         mode;
    logic [7:0] exp;
  } vec_t;

  vec_t       vecs[10];
  logic [7:0] sb_q[$];
  int         total = 0;
  int         bad   = 0;
  int         ph    = 0;
  int         mode  = 1;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic pat_bit(input int m, input int p);
    case (m)
      0:       return 1'b0;
      1:       return 1'b1;
      2:       return p[0];
      3:       return (p % 4) == 0;
      default: return (p % 4) != 0;
    endcase
  endfunction

  // One clock: score a transfer that the coming edge performs, then advance
  task automatic tick();
    if (sample_valid === 1'b1 && sample_ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_xfer: got sample %0d with nothing expected", sample);
      end else begin
        check("xfer_sample", int'(sample), int'(sb_q.pop_front()));
      end
    end
    @(negedge clk);
    ph++;
    bit_in = pat_bit(mode, ph);
  endtask

  task automatic wait_valid(input int budget, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (sample_valid !== 1'b1 && n < budget);
    check("valid_seen", int'(sample_valid), 1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int nwin;
    int busy_cnt;

    vecs[0] = '{2'd2, 1, 8'hFF};
    vecs[1] = '{2'd0, 2, 8'h80};
    vecs[2] = '{2'd3, 2, 8'h80};
    vecs[3] = '{2'd1, 0, 8'h00};
    vecs[4] = '{2'd0, 1, 8'hFF};
    vecs[5] = '{2'd3, 1, 8'hFF};
    vecs[6] = '{2'd0, 3, 8'h40};
    vecs[7] = '{2'd1, 3, 8'h40};
    vecs[8] = '{2'd3, 4, 8'hC0};
    vecs[9] = '{2'd2, 4, 8'hC0};

    rst_n = 1'b0; enable = 1'b0; bit_in = 1'b1; osr_sel = 2'd0;
    clear_ovr = 1'b0; sample_ready = 1'b0; mode = 1;
    repeat (3) tick();
    check("rst_sample", int'(sample), 0);
    check("rst_valid", int'(sample_valid), 0);
    check("rst_overrun", int'(overrun), 0);
    check("rst_busy", int'(busy), 0);

    rst_n = 1'b1;
    busy_cnt = 0;
    repeat (20) begin
      tick();
      if (busy !== 1'b0) busy_cnt++;
    end
    check("idle_busy_cycles", busy_cnt, 0);
    check("idle_valid", int'(sample_valid), 0);

    // Table: two back-to-back windows per record with ready held high
    for (int i = 0; i < 10; i++) begin
      nwin = 64 << vecs[i].osr;
      enable = 1'b0; mode = vecs[i].mode; osr_sel = vecs[i].osr; sample_ready = 1'b1;
      repeat (2) tick();
      sb_q.push_back(vecs[i].exp);
      sb_q.push_back(vecs[i].exp);
      enable = 1'b1;
      wait_valid(nwin + 10, n);
      check("first_latency", n, nwin + 3);
      wait_valid(nwin + 10, n);
      check("window_interval", n, nwin);
      enable = 1'b0;
      tick();
      check("table_sb_empty", sb_q.size(), 0);
      check("table_overrun", int'(overrun), 0);
    end

    // Back-pressure: held sample, overrun, set-wins, clear, release
    enable = 1'b0; sample_ready = 1'b0; mode = 0; osr_sel = 2'd1;
    repeat (2) tick();
    sb_q.push_back(8'h00);
    enable = 1'b1;
    wait_valid(140, n);
    check("bp_latency", n, 131);
    check("bp_ovr_w1", int'(overrun), 0);
    repeat (127) tick();
    check("bp_ovr_before_w2", int'(overrun), 0);
    tick();
    check("bp_ovr_w2", int'(overrun), 1);
    check("bp_valid_held", int'(sample_valid), 1);
    repeat (127) tick();
    clear_ovr = 1'b1;
    tick();
    check("bp_set_wins", int'(overrun), 1);
    check("bp_sample_held", int'(sample), 0);
    tick();
    check("bp_clear", int'(overrun), 0);
    clear_ovr = 1'b0;
    mode = 1; bit_in = 1'b1;
    sample_ready = 1'b1;
    tick();
    check("bp_valid_drop", int'(sample_valid), 0);
    sb_q.push_back(8'hFA);
    wait_valid(140, n);
    check("bp_next_latency", n, 126);
    enable = 1'b0;
    tick();
    check("bp_sb_empty", sb_q.size(), 0);

    // Abort mid-window keeps a pending sample transferable
    sample_ready = 1'b0; mode = 1; osr_sel = 2'd0;
    tick();
    sb_q.push_back(8'hFF);
    enable = 1'b1;
    wait_valid(80, n);
    check("ab_latency", n, 67);
    enable = 1'b0;
    repeat (2) tick();
    osr_sel = 2'd2; mode = 2; enable = 1'b1;
    tick();
    check("ab_busy_rise", int'(busy), 1);
    repeat (101) tick();
    enable = 1'b0;
    tick();
    check("ab_busy_fall", int'(busy), 0);
    repeat (300) tick();
    check("ab_valid_kept", int'(sample_valid), 1);
    check("ab_sample_kept", int'(sample), 255);
    check("ab_no_overrun", int'(overrun), 0);
    sample_ready = 1'b1;
    tick();
    check("ab_valid_drop", int'(sample_valid), 0);
    sb_q.push_back(8'h80);
    enable = 1'b1;
    wait_valid(270, n);
    check("ab_relatency", n, 259);
    enable = 1'b0;
    tick();

    // osr change mid-window affects only the following window
    mode = 3; osr_sel = 2'd2; sample_ready = 1'b1;
    repeat (2) tick();
    sb_q.push_back(8'h40);
    sb_q.push_back(8'h40);
    enable = 1'b1;
    repeat (50) tick();
    osr_sel = 2'd0;
    wait_valid(270, n);
    check("osr_first_window", n, 209);
    wait_valid(80, n);
    check("osr_next_window", n, 64);
    tick();
    repeat (20) tick();
    check("pre_rst_busy", int'(busy), 1);
    check("pre_rst_sample", int'(sample), 64);

    // Asynchronous reset mid-window
    rst_n = 1'b0;
    #1;
    check("arst_sample", int'(sample), 0);
    check("arst_valid", int'(sample_valid), 0);
    check("arst_overrun", int'(overrun), 0);
    check("arst_busy", int'(busy), 0);
    enable = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    check("post_rst_busy", int'(busy), 0);
    check("post_rst_valid", int'(sample_valid), 0);
    check("final_sb_empty", sb_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
